// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - packs decoded instruction fields into words and writes them to program memory
// One holding register feeds a stallable write port; tracks count, XOR checksum and completion.
module instruction_loader #(
  parameter int ADDR_W = 8,
  parameter int D_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D_W-1:0]    in_d,
  input  logic              in_b11,
  input  logic              in_b12,
  input  logic              in_b13,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [D_W+2:0]    mem_data,
  output logic              busy,
  output logic              done,
  output logic [D_W+2:0]    checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state_q;
  logic [ADDR_W:0]     rem_q;
  logic [ADDR_W:0]     unacc_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [D_W+2:0]      data_q;
  logic [D_W+2:0]      csum_q;
  logic                busy_q;
  logic                done_q;

  logic [D_W+2:0]      data_d;
  logic                wr_done;
  logic                accept;

  assign data_d   = {in_b13, in_b12, in_b11, in_d};
  assign wr_done  = we_q & mem_ready;
  // The holding register may reload in the same cycle its current word drains.
  assign in_ready = (state_q == S_LOAD) && (unacc_q != '0) && (!we_q || mem_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      unacc_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_q <= '0;
            csum_q <= '0;
            we_q   <= 1'b0;
            if (len != '0) begin
              state_q <= S_LOAD;
              rem_q   <= len;
              unacc_q <= len;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= S_DONE;
              rem_q   <= '0;
              unacc_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wr_done) begin
            addr_q <= addr_q + ADDR_ONE;
            csum_q <= csum_q ^ data_q;
            rem_q  <= rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          if (accept) begin
            data_q  <= data_d;
            we_q    <= 1'b1;
            unacc_q <= unacc_q - CNT_ONE;
          end else if (wr_done) begin
            we_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign checksum = csum_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
